// File: rtl/uart_tx_port_pkg.sv
// Shared definitions for the UART transmitter port: register offsets,
// STATUS bit positions, FSM states and the STATUS word packer.
package uart_tx_port_pkg;

  localparam logic [31:0] OFS_TXD    = 32'h0000_0000;
  localparam logic [31:0] OFS_STATUS = 32'h0000_0004;
  localparam logic [31:0] OFS_CTRL   = 32'h0000_0008;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_DONE  = 3;
  localparam int ST_OVF   = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_START = 2'b01,
    S_DATA  = 2'b10,
    S_STOP  = 2'b11
  } tx_state_e;

  function automatic logic [31:0] pack_status(input logic full, input logic empty,
                                              input logic busy, input logic done,
                                              input logic ovf);
    logic [31:0] s;
    s           = 32'h0000_0000;
    s[ST_FULL]  = full;
    s[ST_EMPTY] = empty;
    s[ST_BUSY]  = busy;
    s[ST_DONE]  = done;
    s[ST_OVF]   = ovf;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_port_tx_fifo.sv
// Byte FIFO with first-word fall-through output; a push while full is only
// taken when a pop happens on the same edge.
module tx_fifo
  import uart_tx_port_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem_r [DEPTH];
  logic [PTR_W-1:0] wptr_r;
  logic [PTR_W-1:0] rptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == (PTR_W+1)'(DEPTH));
  assign empty     = (count_r == '0);
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign dout      = mem_r[rptr_r];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_ok_s) wptr_r <= wptr_r + 1'b1;
      if (pop_ok_s)  rptr_r <= rptr_r + 1'b1;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wptr_r] <= din;
  end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: bus decode with strobe edge detect,
// TX queue, baud-timed frame FSM and sticky status/interrupt flags.
module uart_tx_port
  import uart_tx_port_pkg::*;
#(
  parameter int          CLK_HZ     = 50_000_000,
  parameter int          BAUD       = 9600,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int               DIV       = CLK_HZ / BAUD;
  localparam int               CNT_W     = $clog2(DIV);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

  tx_state_e        state_r;
  logic [CNT_W-1:0] baud_cnt_r;
  logic [2:0]       bit_cnt_r;
  logic [7:0]       shift_r;
  logic             tx_r, done_r, ovf_r, irq_en_r, irq_r;
  logic             wr_q_r, rd_q_r;
  logic             wr_evt_s, rd_evt_s, hit_txd_s, hit_status_s, hit_ctrl_s;
  logic             fifo_full_s, fifo_empty_s, push_s, pop_s, baud_end_s;
  logic             done_next_s, ovf_next_s, irq_en_next_s;
  logic [7:0]       fifo_dout_s;

  assign wr_evt_s     = wr & ~wr_q_r;
  assign rd_evt_s     = rd & ~rd_q_r;
  assign hit_txd_s    = (addr == BASE_ADDR + OFS_TXD);
  assign hit_status_s = (addr == BASE_ADDR + OFS_STATUS);
  assign hit_ctrl_s   = (addr == BASE_ADDR + OFS_CTRL);
  assign baud_end_s   = (baud_cnt_r == BAUD_LAST);
  assign push_s       = wr_evt_s & hit_txd_s & (~fifo_full_s | pop_s);
  assign tx           = tx_r;
  assign irq          = irq_r;

  // Pop only from a queue that was occupied before this edge: IDLE, or the last STOP cycle
  always_comb begin
    pop_s = 1'b0;
    if (fifo_empty_s) begin
      pop_s = 1'b0;
    end else if (state_r == S_IDLE) begin
      pop_s = 1'b1;
    end else if ((state_r == S_STOP) && baud_end_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Next values of the sticky flags; a set beats a same-edge STATUS-read clear
  always_comb begin
    done_next_s   = done_r;
    ovf_next_s    = ovf_r;
    irq_en_next_s = irq_en_r;
    if ((state_r == S_STOP) && baud_end_s && fifo_empty_s) begin
      done_next_s = 1'b1;
    end else if (rd_evt_s && hit_status_s) begin
      done_next_s = 1'b0;
    end else begin
      done_next_s = done_r;
    end
    if (wr_evt_s && hit_txd_s && fifo_full_s && !pop_s) begin
      ovf_next_s = 1'b1;
    end else if (rd_evt_s && hit_status_s) begin
      ovf_next_s = 1'b0;
    end else begin
      ovf_next_s = ovf_r;
    end
    if (wr_evt_s && hit_ctrl_s) begin
      irq_en_next_s = wdata[0];
    end else begin
      irq_en_next_s = irq_en_r;
    end
  end

  // Read mux, shows flag values from before any same-edge clear
  always_comb begin
    rdata = 32'h0000_0000;
    if (rd && hit_status_s) begin
      rdata = pack_status(fifo_full_s, fifo_empty_s, state_r != S_IDLE, done_r, ovf_r);
    end else if (rd && hit_ctrl_s) begin
      rdata = {31'h0000_0000, irq_en_r};
    end else begin
      rdata = 32'h0000_0000;
    end
  end

  // Bus strobe history for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q_r <= 1'b0;
      rd_q_r <= 1'b0;
    end else begin
      wr_q_r <= wr;
      rd_q_r <= rd;
    end
  end

  // Status flags and registered interrupt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_r   <= 1'b0;
      ovf_r    <= 1'b0;
      irq_en_r <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      done_r   <= done_next_s;
      ovf_r    <= ovf_next_s;
      irq_en_r <= irq_en_next_s;
      irq_r    <= irq_en_next_s & done_next_s;
    end
  end

  // Frame FSM: baud counter, bit counter, shifter and line driver
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      baud_cnt_r <= '0;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      tx_r       <= 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          baud_cnt_r <= '0;
          bit_cnt_r  <= 3'd0;
          tx_r       <= 1'b1;
          if (pop_s) begin
            shift_r <= fifo_dout_s;
            tx_r    <= 1'b0;
            state_r <= S_START;
          end
        end
        S_START: begin
          if (baud_end_s) begin
            baud_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            tx_r       <= shift_r[0];
            state_r    <= S_DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_end_s) begin
            baud_cnt_r <= '0;
            if (bit_cnt_r == 3'd7) begin
              tx_r    <= 1'b1;
              state_r <= S_STOP;
            end else begin
              shift_r   <= {1'b0, shift_r[7:1]};
              tx_r      <= shift_r[1];
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_end_s) begin
            baud_cnt_r <= '0;
            if (pop_s) begin
              shift_r <= fifo_dout_s;
              tx_r    <= 1'b0;
              state_r <= S_START;
            end else begin
              tx_r    <= 1'b1;
              state_r <= S_IDLE;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
          end
        end
        default: begin
          baud_cnt_r <= '0;
          tx_r       <= 1'b1;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .din   (wdata[7:0]),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

endmodule
